// File: rtl/rv32i_mmio_pkg.sv
// rv32i_mmio_pkg: MMIO register addresses and UART transmitter states shared by the memory map
package rv32i_mmio_pkg;
  localparam logic [31:0] MMIO_LEDS        = 32'hF000_0000;
  localparam logic [31:0] MMIO_CYCLES      = 32'hF000_0004;
  localparam logic [31:0] MMIO_UART_DATA   = 32'hF000_0008;
  localparam logic [31:0] MMIO_UART_STATUS = 32'hF000_000C;
  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first serial transmitter (start/data in; busy, registered tx out)
module uart_tx import rv32i_mmio_pkg::*; #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  uart_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic last, accept;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  assign accept = start && (state == UART_IDLE || (state == UART_STOP && last));
  assign busy = state != UART_IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= UART_IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      tx <= 1'b1;
    end else if (accept) begin
      state <= UART_START;
      cnt <= '0;
      idx <= '0;
      sh <= data;
      tx <= 1'b0;
    end else if (busy) begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (last)
        case (state)
          UART_START: begin
            state <= UART_DATA;
            tx <= sh[0];
          end
          UART_DATA: begin
            idx <= idx + 1'b1;
            sh <= sh >> 1;
            state <= idx == 3'd7 ? UART_STOP : UART_DATA;
            tx <= idx == 3'd7 ? 1'b1 : sh[1];
          end
          default: begin
            state <= UART_IDLE;
            tx <= 1'b1;
          end
        endcase
    end
endmodule

// File: rtl/rv32i_memory_map.sv
// rv32i_memory_map: RAM + MMIO (LEDs, cycle counter, UART) decode with 1-cycle registered reads
module rv32i_memory_map import rv32i_mmio_pkg::*; #(
  parameter int RAM_WORDS = 1024,
  parameter     INIT_FILE = "",
  parameter int CLK_HZ    = 12_000_000,
  parameter int BAUD      = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wr_data,
  input  logic        core_wr_ena,
  output logic [31:0] core_rd_data,
  output logic [7:0]  leds,
  output logic        uart_tx
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] addr, cycles, ram_q, mmio_q, mmio_rd;
  logic in_ram, sel_ram, busy, unused_lo;
  assign addr = {core_addr[31:2], 2'b00};
  assign unused_lo = ^core_addr[1:0];
  assign in_ram = core_addr[31:AW+2] == '0;
  assign mmio_rd = addr == MMIO_LEDS ? {24'h0, leds} :
                   addr == MMIO_CYCLES ? cycles :
                   addr == MMIO_UART_STATUS ? {31'h0, busy} : '0;
  assign core_rd_data = sel_ram ? ram_q : mmio_q;
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("rv32i_memory_map: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (core_wr_ena && in_ram && !rst) ram[core_addr[AW+1:2]] <= core_wr_data;
    ram_q <= ram[core_addr[AW+1:2]];
  end
  always_ff @(posedge clk)
    if (rst) begin
      leds <= '0;
      cycles <= '0;
      mmio_q <= '0;
      sel_ram <= 1'b0;
    end else begin
      cycles <= cycles + 1'b1;
      mmio_q <= mmio_rd;
      sel_ram <= in_ram;
      if (core_wr_ena && addr == MMIO_LEDS) leds <= core_wr_data[7:0];
    end
  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk   (clk),
    .rst   (rst),
    .start (core_wr_ena && addr == MMIO_UART_DATA),
    .data  (core_wr_data[7:0]),
    .busy  (busy),
    .tx    (uart_tx)
  );
endmodule

// File: tb/tb_rv32i_memory_map.sv
// tb_rv32i_memory_map: directed vector and UART frame checks for rv32i_memory_map
module tb_rv32i_memory_map;
  logic clk = 1'b0, rst = 1'b1, core_wr_ena = 1'b0;
  logic [31:0] core_addr = '0, core_wr_data = '0, core_rd_data;
  logic [7:0] leds;
  logic uart_tx;
  int errors = 0, checks = 0;
  logic [31:0] cyc_n = '0, cyc_at = '0;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic        chk;
    logic [31:0] rd;
    logic [7:0]  leds;
  } vec_t;
  vec_t v[14];
  rv32i_memory_map #(.RAM_WORDS(64), .INIT_FILE(""), .CLK_HZ(4), .BAUD(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_addr    (core_addr),
    .core_wr_data (core_wr_data),
    .core_wr_ena  (core_wr_ena),
    .core_rd_data (core_rd_data),
    .leds         (leds),
    .uart_tx      (uart_tx)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    cyc_at = rst ? '0 : cyc_n;
    cyc_n = rst ? '0 : cyc_n + 1;
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    core_addr = a;
    core_wr_data = d;
    core_wr_ena = we;
  endtask
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    return k == 0 ? 1'b0 : k >= 9 ? 1'b1 : d[k-1];
  endfunction
  initial begin
    v[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         8'h00};
    v[1]  = '{32'h0000_0014, 32'h0000_0000, 1'b1, 1'b0, 32'h0,         8'h00};
    v[2]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 8'h00};
    v[3]  = '{32'h0000_0014, 32'h1234_5678, 1'b1, 1'b1, 32'h0,         8'h00};
    v[4]  = '{32'h0000_0014, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 8'h00};
    v[5]  = '{32'hF000_0000, 32'h0000_01A5, 1'b1, 1'b1, 32'h0,         8'hA5};
    v[6]  = '{32'hF000_0000, 32'h0,         1'b0, 1'b1, 32'h0000_00A5, 8'hA5};
    v[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0,         8'hA5};
    v[8]  = '{32'h8000_0010, 32'h0,         1'b0, 1'b1, 32'h0,         8'hA5};
    v[9]  = '{32'h0000_0110, 32'h0,         1'b0, 1'b1, 32'h0,         8'hA5};
    v[10] = '{32'hF000_0008, 32'h0,         1'b0, 1'b1, 32'h0,         8'hA5};
    v[11] = '{32'hF000_000C, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0,         8'hA5};
    v[12] = '{32'h0000_0013, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 8'hA5};
    v[13] = '{32'hF000_0003, 32'h0,         1'b0, 1'b1, 32'h0000_00A5, 8'hA5};
    tick();
    tick();
    check("reset rd_data", core_rd_data, 32'h0);
    check("reset leds", {24'h0, leds}, 32'h0);
    check("reset uart_tx", {31'h0, uart_tx}, 32'h1);
    rst = 1'b0;
    drive(32'hF000_0004, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("cycles start %0d", i), core_rd_data, 32'(i));
    end
    for (int i = 0; i < 14; i++) begin
      drive(v[i].addr, v[i].wd, v[i].we);
      tick();
      if (v[i].chk) check($sformatf("vec %0d rd", i), core_rd_data, v[i].rd);
      check($sformatf("vec %0d leds", i), {24'h0, leds}, {24'h0, v[i].leds});
    end
    drive(32'hF000_0004, 32'h0, 1'b0);
    tick();
    check("cycles model", core_rd_data, cyc_at);
    drive(32'hF000_0004, 32'h0, 1'b1);
    tick();
    check("cycles during write", core_rd_data, cyc_at);
    drive(32'hF000_0004, 32'h0, 1'b0);
    tick();
    check("cycles after write", core_rd_data, cyc_at);
    drive(32'hF000_0008, 32'h55, 1'b1);
    tick();
    check("0x55 tx 0", {31'h0, uart_tx}, 32'h0);
    for (int i = 1; i <= 48; i++) begin
      drive(i == 10 ? 32'hF000_0008 : 32'hF000_000C, 32'h0, i == 10);
      tick();
      check($sformatf("0x55 tx %0d", i), {31'h0, uart_tx}, {31'h0, frame_bit(8'h55, i / 4)});
      if (i <= 41) check($sformatf("0x55 status %0d", i), core_rd_data, i == 10 ? 32'h0 : {31'h0, i <= 40});
    end
    drive(32'hF000_0008, 32'hA3, 1'b1);
    tick();
    check("b2b tx 0", {31'h0, uart_tx}, 32'h0);
    for (int i = 1; i <= 82; i++) begin
      drive(32'hF000_0008, 32'h0F, i == 40);
      tick();
      check($sformatf("b2b tx %0d", i), {31'h0, uart_tx},
            {31'h0, i < 40 ? frame_bit(8'hA3, i / 4) : frame_bit(8'h0F, (i - 40) / 4)});
    end
    drive(32'h0000_0020, 32'hCAFE_F00D, 1'b1);
    tick();
    drive(32'hF000_0008, 32'h00, 1'b1);
    tick();
    for (int i = 1; i <= 17; i++) begin
      drive(32'h0, 32'h0, 1'b0);
      tick();
    end
    check("abort pre tx", {31'h0, uart_tx}, 32'h0);
    rst = 1'b1;
    drive(32'hF000_0000, 32'h77, 1'b1);
    tick();
    check("abort tx", {31'h0, uart_tx}, 32'h1);
    check("abort leds", {24'h0, leds}, 32'h0);
    rst = 1'b0;
    drive(32'hF000_000C, 32'h0, 1'b0);
    tick();
    check("abort status", core_rd_data, 32'h0);
    drive(32'h0000_0020, 32'h0, 1'b0);
    tick();
    check("ram after reset", core_rd_data, 32'hCAFE_F00D);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("idle after abort %0d", i), {31'h0, uart_tx}, 32'h1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
